// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source end of a 4-phase req/ack crossing; optional CDC_TX_TIMEOUT_EN phase timeout
module cdc_handshake_tx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack,
    output logic              busy,
`ifdef CDC_TX_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              ack_s;
    logic              req_nx, busy_nx, done_nx;
    logic [DATA_W-1:0] data_nx;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             tmo_nx;
    // A word whose request timed out must not report done when the ack side settles.
    logic             aborted, aborted_nx;
`endif

    cdc_handshake_tx_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .d  (xfer_ack),
        .q  (ack_s)
    );

    assign src_ready = (state == IDLE) && !ack_s;

    always_comb begin
        state_nx = state;
        req_nx   = xfer_req;
        data_nx  = xfer_data;
        busy_nx  = busy;
        done_nx  = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        cnt_nx     = cnt + CNT_W'(1);
        tmo_nx     = 1'b0;
        aborted_nx = aborted;
`endif
        case (state)
            IDLE: begin
                if (src_valid && src_ready) begin
                    data_nx  = src_data;
                    req_nx   = 1'b1;
                    busy_nx  = 1'b1;
                    state_nx = REQ_HI;
`ifdef CDC_TX_TIMEOUT_EN
                    cnt_nx     = '0;
                    aborted_nx = 1'b0;
`endif
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_nx   = 1'b0;
                    state_nx = REQ_LO;
`ifdef CDC_TX_TIMEOUT_EN
                    cnt_nx = '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    req_nx     = 1'b0;
                    tmo_nx     = 1'b1;
                    aborted_nx = 1'b1;
                    state_nx   = REQ_LO;
                    cnt_nx     = '0;
`endif
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
`ifdef CDC_TX_TIMEOUT_EN
                    done_nx = !aborted;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    tmo_nx = 1'b1;
`else
                    done_nx = 1'b1;
`endif
                end
            end
            default: begin
                state_nx = IDLE;
                req_nx   = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            xfer_req  <= req_nx;
            xfer_data <= data_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            timeout_err <= tmo_nx;
            aborted     <= aborted_nx;
        end
    end
`endif

endmodule
